// File: rtl/write_back_if.sv
// Bus between the pipeline and the W stage: M-stage results in, W-register
// state, decode register reads and processor status out.
interface write_back_if #(
  parameter int DATA_W = 64
);
  logic              stall_i;
  logic              bubble_i;
  logic [3:0]        icode_i;
  logic [2:0]        stat_i;
  logic [DATA_W-1:0] valE_i;
  logic [DATA_W-1:0] valM_i;
  logic [3:0]        dstE_i;
  logic [3:0]        dstM_i;
  logic [3:0]        srcA_i;
  logic [3:0]        srcB_i;
  logic [DATA_W-1:0] valA_o;
  logic [DATA_W-1:0] valB_o;
  logic [3:0]        W_icode_o;
  logic [3:0]        W_dstE_o;
  logic [DATA_W-1:0] W_valE_o;
  logic [3:0]        W_dstM_o;
  logic [DATA_W-1:0] W_valM_o;
  logic [2:0]        stat_o;
  logic              halted_o;
  logic [63:0]       retired_o;

  modport master (
    output stall_i, bubble_i, icode_i, stat_i, valE_i, valM_i, dstE_i, dstM_i,
           srcA_i, srcB_i,
    input  valA_o, valB_o, W_icode_o, W_dstE_o, W_valE_o, W_dstM_o, W_valM_o,
           stat_o, halted_o, retired_o
  );

  modport slave (
    input  stall_i, bubble_i, icode_i, stat_i, valE_i, valM_i, dstE_i, dstM_i,
           srcA_i, srcB_i,
    output valA_o, valB_o, W_icode_o, W_dstE_o, W_valE_o, W_dstM_o, W_valM_o,
           stat_o, halted_o, retired_o
  );
endinterface

// File: rtl/write_back.sv
// Y86-64 write-back stage: W pipeline register, 15-entry register file with
// E/M write ports and bypassed decode reads, sticky halt and retire counter.
module write_back #(
  parameter int                DATA_W   = 64,
  parameter int                NREG     = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input logic        clk_i,
  input logic        rst_i,
  write_back_if.slave bus
);

  typedef enum logic [2:0] {
    STAT_BUBBLE = 3'd0,
    STAT_OK     = 3'd1,
    STAT_ADR    = 3'd2,
    STAT_INS    = 3'd3,
    STAT_HLT    = 3'd4
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] INOP  = 4'h1;

  logic [3:0]        w_icode;
  stat_e             w_stat;
  logic [DATA_W-1:0] w_valE;
  logic [DATA_W-1:0] w_valM;
  logic [3:0]        w_dstE;
  logic [3:0]        w_dstM;
  logic              halted;
  stat_e             halt_stat;
  logic [63:0]       retired;
  logic [DATA_W-1:0] rf [NREG];
  logic              wr_ok;
  logic              we_e;
  logic              we_m;

  // W pipeline register: reset > halted > stall > bubble > load
  always_ff @(posedge clk_i) begin
    if (rst_i || (!halted && !bus.stall_i && bus.bubble_i)) begin
      w_icode <= INOP;
      w_stat  <= STAT_BUBBLE;
      w_valE  <= '0;
      w_valM  <= '0;
      w_dstE  <= RNONE;
      w_dstM  <= RNONE;
    end else if (!halted && !bus.stall_i) begin
      w_icode <= bus.icode_i;
      w_stat  <= stat_e'(bus.stat_i);
      w_valE  <= bus.valE_i;
      w_valM  <= bus.valM_i;
      w_dstE  <= bus.dstE_i;
      w_dstM  <= bus.dstM_i;
    end
  end

  // Write enables derived from the instruction currently in W
  always_comb begin
    wr_ok = !halted && (w_stat == STAT_OK);
    we_e  = wr_ok && (w_dstE != RNONE);
    we_m  = wr_ok && (w_dstM != RNONE);
  end

  // Register file; M write is issued last so it wins when dstE == dstM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf[i] <= (i == 4) ? RSP_INIT : '0;
      end
    end else begin
      if (we_e) rf[w_dstE] <= w_valE;
      if (we_m) rf[w_dstM] <= w_valM;
    end
  end

  // Sticky halt; the faulting status is captured because W keeps loading
  // on the same edge the halt is detected
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halted    <= 1'b0;
      halt_stat <= STAT_BUBBLE;
    end else if (!halted && (w_stat == STAT_HLT || w_stat == STAT_ADR ||
                             w_stat == STAT_INS)) begin
      halted    <= 1'b1;
      halt_stat <= w_stat;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) retired <= '0;
    else if (wr_ok) retired <= retired + 64'd1;
  end

  // Decode reads with write-first bypass (M over E)
  always_comb begin
    bus.valA_o = '0;
    if (bus.srcA_i != RNONE) begin
      if (we_m && bus.srcA_i == w_dstM)      bus.valA_o = w_valM;
      else if (we_e && bus.srcA_i == w_dstE) bus.valA_o = w_valE;
      else                                   bus.valA_o = rf[bus.srcA_i];
    end
  end

  // Second decode read port, same rules as port A
  always_comb begin
    bus.valB_o = '0;
    if (bus.srcB_i != RNONE) begin
      if (we_m && bus.srcB_i == w_dstM)      bus.valB_o = w_valM;
      else if (we_e && bus.srcB_i == w_dstE) bus.valB_o = w_valE;
      else                                   bus.valB_o = rf[bus.srcB_i];
    end
  end

  // Registered state to the outside world
  always_comb begin
    bus.W_icode_o = w_icode;
    bus.W_dstE_o  = w_dstE;
    bus.W_valE_o  = w_valE;
    bus.W_dstM_o  = w_dstM;
    bus.W_valM_o  = w_valM;
    bus.stat_o    = halted ? halt_stat : w_stat;
    bus.halted_o  = halted;
    bus.retired_o = retired;
  end

endmodule

// File: tb/tb_write_back.sv
// Testbench for write_back: directed vector table followed by random traffic
// checked against a behavioural model of the W stage.
module tb_write_back;

  localparam logic [63:0] RSP = 64'h100;
  localparam logic [3:0]  RN  = 4'hF;
  localparam logic [2:0]  S_BUB = 3'd0, S_OK = 3'd1, S_ADR = 3'd2,
                          S_INS = 3'd3, S_HLT = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  write_back_if #(.DATA_W(64)) bus ();

  write_back #(.DATA_W(64), .NREG(15), .RSP_INIT(RSP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } wreg_t;

  // Behavioural model state
  wreg_t       mw;
  logic [63:0] mR [15];
  logic        m_halted;
  logic [2:0]  m_hstat;
  logic [63:0] m_retired;

  task automatic model_reset();
    mw = '{4'h1, S_BUB, 64'h0, 64'h0, RN, RN};
    for (int i = 0; i < 15; i++) mR[i] = (i == 4) ? RSP : 64'h0;
    m_halted  = 1'b0;
    m_hstat   = S_BUB;
    m_retired = 64'h0;
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] src);
    logic ok;
    ok = !m_halted && mw.stat == S_OK;
    if (src == RN) return 64'h0;
    if (ok && mw.dstM == src) return mw.valM;
    if (ok && mw.dstE == src) return mw.valE;
    return mR[src];
  endfunction

  // One rising edge of the spec's behaviour, using the inputs currently driven
  task automatic model_edge();
    logic was_halted;
    if (rst) begin
      model_reset();
      return;
    end
    was_halted = m_halted;
    if (!m_halted && mw.stat == S_OK) begin
      if (mw.dstE != RN) mR[mw.dstE] = mw.valE;
      if (mw.dstM != RN) mR[mw.dstM] = mw.valM;
      m_retired = m_retired + 1;
    end
    if (!m_halted && (mw.stat == S_HLT || mw.stat == S_ADR || mw.stat == S_INS)) begin
      m_halted = 1'b1;
      m_hstat  = mw.stat;
    end
    if (!was_halted && !bus.stall_i) begin
      if (bus.bubble_i) mw = '{4'h1, S_BUB, 64'h0, 64'h0, RN, RN};
      else mw = '{bus.icode_i, bus.stat_i, bus.valE_i, bus.valM_i, bus.dstE_i, bus.dstM_i};
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic bb,
                       input logic [3:0] ic, input logic [2:0] s,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [3:0] sa, input logic [3:0] sb);
    rst          = r;
    bus.stall_i  = st;
    bus.bubble_i = bb;
    bus.icode_i  = ic;
    bus.stat_i   = s;
    bus.valE_i   = ve;
    bus.valM_i   = vm;
    bus.dstE_i   = de;
    bus.dstM_i   = dm;
    bus.srcA_i   = sa;
    bus.srcB_i   = sb;
  endtask

  // Advance one edge, keep the model in step, settle past the edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        rst, stall, bubble;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] valE, valM;
    logic [3:0]  dstE, dstM, srcA, srcB;
    logic [3:0]  e_icode, e_dstE;
    logic [63:0] e_valE, e_valA, e_valB;
    logic [2:0]  e_stat;
    logic        e_halted;
    logic [63:0] e_retired;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{1,0,0, 4'h0,S_BUB,64'h0,64'h0,RN,RN, 4'd4,4'd3, 4'h1,RN,64'h0, RSP,64'h0, S_BUB,0,64'd0};
    vt[1]  = '{1,0,0, 4'h0,S_BUB,64'h0,64'h0,RN,RN, 4'd4,4'd3, 4'h1,RN,64'h0, RSP,64'h0, S_BUB,0,64'd0};
    vt[2]  = '{0,0,0, 4'h3,S_OK,64'h1234,64'h0,4'd2,RN, 4'd2,4'd4, 4'h3,4'd2,64'h1234, 64'h1234,RSP, S_OK,0,64'd0};
    vt[3]  = '{0,0,0, 4'hB,S_OK,64'h108,64'hAA,4'd4,4'd4, 4'd2,4'd4, 4'hB,4'd4,64'h108, 64'h1234,64'hAA, S_OK,0,64'd1};
    vt[4]  = '{0,0,1, 4'h3,S_OK,64'h77,64'h0,4'd3,RN, 4'd4,4'd3, 4'h1,RN,64'h0, 64'hAA,64'h0, S_BUB,0,64'd2};
    vt[5]  = '{0,1,0, 4'h6,S_OK,64'h999,64'h0,4'd5,RN, 4'd4,4'd3, 4'h1,RN,64'h0, 64'hAA,64'h0, S_BUB,0,64'd2};
    vt[6]  = '{0,0,0, 4'h3,S_OK,64'h77,64'h0,4'd3,RN, 4'd4,4'd3, 4'h3,4'd3,64'h77, 64'hAA,64'h77, S_OK,0,64'd2};
    vt[7]  = '{0,0,0, 4'h3,S_ADR,64'h5,64'h0,4'd1,RN, 4'd1,4'd3, 4'h3,4'd1,64'h5, 64'h0,64'h77, S_ADR,0,64'd3};
    vt[8]  = '{0,0,0, 4'h3,S_OK,64'h9,64'h0,4'd6,RN, 4'd1,4'd6, 4'h3,4'd6,64'h9, 64'h0,64'h0, S_ADR,1,64'd3};
    vt[9]  = '{0,0,0, 4'h6,S_OK,64'h11,64'h0,4'd7,RN, 4'd1,4'd6, 4'h3,4'd6,64'h9, 64'h0,64'h0, S_ADR,1,64'd3};
    vt[10] = '{1,0,0, 4'h0,S_BUB,64'h0,64'h0,RN,RN, 4'd4,4'd1, 4'h1,RN,64'h0, RSP,64'h0, S_BUB,0,64'd0};

    model_reset();
    drive(1, 0, 0, 4'h0, S_BUB, 64'h0, 64'h0, RN, RN, 4'd4, 4'd3);
    @(negedge clk);

    // Directed sequence: reset, irmovq, popq %rsp, bubble, stall, halt, reset
    for (int k = 0; k < 11; k++) begin
      drive(vt[k].rst, vt[k].stall, vt[k].bubble, vt[k].icode, vt[k].stat,
            vt[k].valE, vt[k].valM, vt[k].dstE, vt[k].dstM, vt[k].srcA, vt[k].srcB);
      step();
      chk($sformatf("v%0d W_icode", k), {60'h0, bus.W_icode_o}, {60'h0, vt[k].e_icode});
      chk($sformatf("v%0d W_dstE", k),  {60'h0, bus.W_dstE_o},  {60'h0, vt[k].e_dstE});
      chk($sformatf("v%0d W_valE", k),  bus.W_valE_o, vt[k].e_valE);
      chk($sformatf("v%0d valA", k),    bus.valA_o,   vt[k].e_valA);
      chk($sformatf("v%0d valB", k),    bus.valB_o,   vt[k].e_valB);
      chk($sformatf("v%0d stat", k),    {61'h0, bus.stat_o}, {61'h0, vt[k].e_stat});
      chk($sformatf("v%0d halted", k),  {63'h0, bus.halted_o}, {63'h0, vt[k].e_halted});
      chk($sformatf("v%0d retired", k), bus.retired_o, vt[k].e_retired);
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] s;
      int unsigned r;
      r = $urandom_range(0, 19);
      s = (r == 0) ? S_HLT : (r == 1) ? S_ADR : (r == 2) ? S_INS : (r == 3) ? S_BUB : S_OK;
      drive(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)), s,
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? RN : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : RN,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
      chk("rnd W_icode", {60'h0, bus.W_icode_o}, {60'h0, mw.icode});
      chk("rnd W_dstE",  {60'h0, bus.W_dstE_o},  {60'h0, mw.dstE});
      chk("rnd W_valE",  bus.W_valE_o, mw.valE);
      chk("rnd W_dstM",  {60'h0, bus.W_dstM_o},  {60'h0, mw.dstM});
      chk("rnd W_valM",  bus.W_valM_o, mw.valM);
      chk("rnd stat",    {61'h0, bus.stat_o}, {61'h0, m_halted ? m_hstat : mw.stat});
      chk("rnd halted",  {63'h0, bus.halted_o}, {63'h0, m_halted});
      chk("rnd retired", bus.retired_o, m_retired);
      chk("rnd valA",    bus.valA_o, m_read(bus.srcA_i));
      chk("rnd valB",    bus.valB_o, m_read(bus.srcB_i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
